// File: rtl/axis_rr_pick.sv
// Round-robin priority search: finds the first requesting port starting at
// ptr_i and wrapping modulo NS.
module axis_rr_pick #(
    parameter int unsigned NS = 4,
    parameter int unsigned IW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic [NS-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          gnt_vld_o,
    output logic [IW-1:0] gnt_idx_o
);

    // Port index reached by stepping 'off' places past the pointer, modulo NS.
    function automatic int unsigned wrap_idx(input logic [IW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= NS) begin
            s = s - NS;
        end
        return s;
    endfunction

    logic found;

    // Scan offsets 0..NS-1 from the pointer; the first requester wins.
    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            for (int unsigned j = 0; j < NS; j++) begin
                if (!found && (wrap_idx(ptr_i, i) == j) && req_i[j]) begin
                    found     = 1'b1;
                    gnt_idx_o = IW'(j);
                end
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/axis_rr_merge.sv
// Packet-level round-robin merge of NS AXI-Stream inputs into one registered
// output stream. A multi-beat packet locks the arbiter until its TLAST.
module axis_rr_merge #(
    parameter int unsigned C_AXIS_DATA_WIDTH = 16,
    parameter int unsigned NS                = 4,
    parameter int unsigned IW                = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [NS-1:0]                   S_AXIS_TVALID,
    output logic [NS-1:0]                   S_AXIS_TREADY,
    input  logic [NS*C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NS-1:0]                   S_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    output logic [IW-1:0]                   M_AXIS_TID
);

    localparam int unsigned DW = C_AXIS_DATA_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   lock_q, lock_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_last_q, m_last_d;
    logic [IW-1:0]   m_tid_q, m_tid_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            open_stage;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic            sel_valid;
    logic [DW-1:0]   sel_data;
    logic            sel_last;
    logic            accept;
    logic [IW-1:0]   nxt_idx;

    axis_rr_pick #(
        .NS (NS),
        .IW (IW)
    ) u_pick (
        .req_i     (S_AXIS_TVALID),
        .ptr_i     (ptr_q),
        .gnt_vld_o (pick_vld),
        .gnt_idx_o (pick_idx)
    );

    assign open_stage = !m_valid_q || M_AXIS_TREADY;

    // Grant selection: a locked packet owns the output, otherwise the picker decides.
    always_comb begin
        gnt_vld = pick_vld;
        gnt_idx = pick_idx;
        if (state_q == LOCKED) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_q;
        end
    end

    // Route the granted port's beat and drive per-port ready.
    always_comb begin
        sel_valid     = 1'b0;
        sel_data      = '0;
        sel_last      = 1'b0;
        S_AXIS_TREADY = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (IW'(k) == gnt_idx) begin
                sel_valid        = S_AXIS_TVALID[k];
                sel_data         = S_AXIS_TDATA[k*DW +: DW];
                sel_last         = S_AXIS_TLAST[k];
                S_AXIS_TREADY[k] = gnt_vld && open_stage && !S_AXI_ARESET;
            end
        end
        accept  = gnt_vld && sel_valid && open_stage && !S_AXI_ARESET;
        nxt_idx = (gnt_idx == IW'(NS - 1)) ? '0 : gnt_idx + IW'(1);
    end

    // Next state: lock on a non-final beat, advance the pointer past the
    // source when a packet ends.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (sel_last) begin
                        ptr_d = nxt_idx;
                    end else begin
                        state_d = LOCKED;
                        lock_d  = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_d = IDLE;
                        ptr_d   = nxt_idx;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output stage: load on accept (also covers drain+reload), clear on drain.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_tid_d   = m_tid_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_tid_d   = gnt_idx;
        end else if (M_AXIS_TREADY) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lock_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_tid_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_tid_q   <= m_tid_d;
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TID    = m_tid_q;

endmodule

// File: doc/axis_rr_merge.md
AXIS_RR_MERGE -- requirements
Module: axis_rr_merge

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 16: TDATA width per port.
REQ-002 Parameter NS, default 4: number of slave (incoming) stream ports, NS >= 1.
REQ-003 Parameter IW, default 2: TID width, max(1, clog2(NS)).
REQ-004 S_AXI_ACLK  input  1  sole clock; all logic on its rising edge.
REQ-005 S_AXI_ARESET  input  1  reset, asynchronous, active-high.
REQ-006 S_AXIS_TVALID  input  NS  per-port valid.
REQ-007 S_AXIS_TREADY  output  NS  per-port ready.
REQ-008 S_AXIS_TDATA  input  NS*C_AXIS_DATA_WIDTH  port k at bits [k*DW +: DW].
REQ-009 S_AXIS_TLAST  input  NS  per-port end-of-packet.
REQ-010 M_AXIS_TVALID  output  1  merged valid.
REQ-011 M_AXIS_TREADY  input  1  merged ready.
REQ-012 M_AXIS_TDATA  output  C_AXIS_DATA_WIDTH  merged data.
REQ-013 M_AXIS_TLAST  output  1  merged end-of-packet.
REQ-014 M_AXIS_TID  output  IW  index of the source port of the current beat.

Function
REQ-015 Block SHALL merge NS streams, one packet at a time, into one stream; packets never interleave on the output.
REQ-016 Output SHALL be a single registered stage: M_AXIS_* are driven only from flops.
REQ-017 Output stage "open" = !M_AXIS_TVALID || M_AXIS_TREADY; S_AXIS_TREADY[k] SHALL be high only when port k is granted and the stage is open.
REQ-018 FSM states IDLE and LOCKED; a 2-bit-free pointer rr_ptr (IW bits) holds the highest-priority port.
REQ-019 IDLE: grant SHALL go combinationally to the first valid port searching rr_ptr, rr_ptr+1, ... wrapping modulo NS; no valid ports -> no grant, all TREADY low.
REQ-020 IDLE, granted beat accepted with TLAST=1: stay IDLE, rr_ptr <= granted+1 (mod NS).
REQ-021 IDLE, granted beat accepted with TLAST=0: go LOCKED, latch lock index = granted.
REQ-022 LOCKED: only the locked port is granted regardless of other valids; on accepted beat with TLAST=1 -> IDLE, rr_ptr <= locked+1 (mod NS).
REQ-023 LOCKED with locked port's TVALID low: output stalls, no other port served.
REQ-024 Accepted beat SHALL appear on M_AXIS_* exactly 1 cycle later with TID = source index; sustained throughput 1 beat/cycle while M_AXIS_TREADY high.
REQ-025 M_AXIS_TVALID high and M_AXIS_TREADY low: M_AXIS_TDATA/TLAST/TID SHALL hold stable and all S_AXIS_TREADY low.
REQ-026 Simultaneous output drain and new accept in one cycle SHALL reload the register without a bubble.
REQ-027 Wrap: NS not a power of two -> rr_ptr increments from NS-1 to 0, never reaches NS.
REQ-028 NS=1: arbiter degenerates to pass-through register, TID constant 0.

Reset
REQ-029 On S_AXI_ARESET high (any time, asynchronously): M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TID=0, state=IDLE, rr_ptr=0, lock index=0.
REQ-030 Reset mid-packet SHALL discard the partial packet and the held beat; no recovery of the lock.
REQ-031 During reset all S_AXIS_TREADY SHALL be low.

Structure
REQ-032 No shared package required; IW derived locally as a constant, no typedefs exported.
REQ-033 Round-robin priority search SHALL live in one sub-module, axis_rr_pick (inputs: request vector, pointer; outputs: grant valid, grant index).
REQ-034 FSM, lock index, pointer and output register stay in axis_rr_merge; target 120-400 RTL lines.

Verification
REQ-035 Ports 0 and 2 both send 1-beat packets (0xAAAA, 0xCCCC) every cycle, M ready -> output alternates TID 0,2,0,2 at 1 beat/cycle.
REQ-036 Port 1 sends 3-beat packet 0x0011,0x0012,0x0013(last) while port 3 valid throughout -> all three port-1 beats contiguous with TID=1, then port 3 with TID=3.
REQ-037 M_AXIS_TREADY held low 4 cycles with beat 0x1234 pending -> TVALID, TDATA=0x1234, TLAST, TID stable 4 cycles; S_AXIS_TREADY all low.
REQ-038 Port 1 drops TVALID mid-packet for 3 cycles while port 0 valid -> output idles 3 cycles, port 0 not served until port 1 TLAST.
REQ-039 Reset asserted mid-packet from port 2 -> next cycle M_AXIS_TVALID=0, state IDLE, rr_ptr=0; afterward port 0 granted first when ports 0 and 2 both valid.
REQ-040 NS=3, all ports continuously valid with 1-beat packets -> TID sequence 0,1,2,0,1,2 (wrap without index 3).
